// File: rtl/ssim_pkg.sv
// Shared constants for the SSIM numerator/denominator combine stage:
// stabiliser defaults, lane widths, pipeline depth and frame-size helper.
package ssim_pkg;

    localparam int C1_DEF   = 7;
    localparam int C2_DEF   = 59;
    localparam int MU_W     = 8;
    localparam int SIG_W    = 16;
    localparam int MID_W    = 18;
    localparam int OUT_W    = 36;
    localparam int SSIM_LAT = 3;

    function automatic int frame_beats(input int dim, input int ppb);
        return (dim * dim) / ppb;
    endfunction

endpackage

// File: rtl/ssim_lane.sv
// One pixel lane of the SSIM combine: products, stabilised sums, then the
// final num/den multiplies. Stage enables come from the top-level valid pipe.
module ssim_lane
    import ssim_pkg::*;
#(
    parameter int C1 = C1_DEF,
    parameter int C2 = C2_DEF
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [2:0]       en_i,
    input  logic [MU_W-1:0]  mu_x_i,
    input  logic [MU_W-1:0]  mu_y_i,
    input  logic [SIG_W-1:0] sigma_xy_i,
    input  logic [SIG_W-1:0] sigma_x2_i,
    input  logic [SIG_W-1:0] sigma_y2_i,
    output logic [OUT_W-1:0] num_o,
    output logic [OUT_W-1:0] den_o
);

    logic [SIG_W-1:0]        p_xy_q, p_xx_q, p_yy_q, s_xy_q;
    logic [SIG_W:0]          s_sum_q;
    logic [MID_W-1:0]        a_q, d1_q, d2_q;
    logic signed [MID_W-1:0] b_q;
    logic [OUT_W-1:0]        num_q, den_q;

    logic [SIG_W-1:0]        p_xy_d, p_xx_d, p_yy_d;
    logic [SIG_W:0]          s_sum_d;
    logic [MID_W-1:0]        a_d, b_d, d1_d, d2_d;
    logic signed [OUT_W-1:0] num_d;
    logic [OUT_W-1:0]        den_d;

    assign p_xy_d  = SIG_W'(mu_x_i) * SIG_W'(mu_y_i);
    assign p_xx_d  = SIG_W'(mu_x_i) * SIG_W'(mu_x_i);
    assign p_yy_d  = SIG_W'(mu_y_i) * SIG_W'(mu_y_i);
    assign s_sum_d = (SIG_W+1)'(sigma_x2_i) + (SIG_W+1)'(sigma_y2_i);

    // Covariance is sign-extended before doubling so negative values survive.
    assign a_d  = {1'b0, p_xy_q, 1'b0} + MID_W'(C1);
    assign b_d  = {s_xy_q[SIG_W-1], s_xy_q, 1'b0} + MID_W'(C2);
    assign d1_d = MID_W'(p_xx_q) + MID_W'(p_yy_q) + MID_W'(C1);
    assign d2_d = MID_W'(s_sum_q) + MID_W'(C2);

    assign num_d = OUT_W'($signed({1'b0, a_q})) * OUT_W'(b_q);
    assign den_d = OUT_W'(d1_q) * OUT_W'(d2_q);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            p_xy_q  <= '0;
            p_xx_q  <= '0;
            p_yy_q  <= '0;
            s_xy_q  <= '0;
            s_sum_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            num_q   <= '0;
            den_q   <= '0;
        end else begin
            if (en_i[0]) begin
                p_xy_q  <= p_xy_d;
                p_xx_q  <= p_xx_d;
                p_yy_q  <= p_yy_d;
                s_xy_q  <= sigma_xy_i;
                s_sum_q <= s_sum_d;
            end
            if (en_i[1]) begin
                a_q  <= a_d;
                b_q  <= $signed(b_d);
                d1_q <= d1_d;
                d2_q <= d2_d;
            end
            if (en_i[2]) begin
                num_q <= num_d;
                den_q <= den_d;
            end
        end
    end

    assign num_o = num_q;
    assign den_o = den_q;

endmodule

// File: rtl/ssim_num_den.sv
// SSIM numerator/denominator combine: PPB independent lanes under a global
// stall, plus the valid/last pipe and the per-frame beat counter.
module ssim_num_den
    import ssim_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int C1              = C1_DEF,
    parameter int C2              = C2_DEF
) (
    input  logic                               clk,
    input  logic                               aresetn,
    input  logic                               stall,
    input  logic                               in_valid,
    input  logic [MU_W*PIXELS_PER_BEAT-1:0]    mu_x,
    input  logic [MU_W*PIXELS_PER_BEAT-1:0]    mu_y,
    input  logic [SIG_W*PIXELS_PER_BEAT-1:0]   sigma_xy,
    input  logic [SIG_W*PIXELS_PER_BEAT-1:0]   sigma_x2,
    input  logic [SIG_W*PIXELS_PER_BEAT-1:0]   sigma_y2,
    output logic [OUT_W*PIXELS_PER_BEAT-1:0]   num,
    output logic [OUT_W*PIXELS_PER_BEAT-1:0]   den,
    output logic                               out_valid,
    output logic                               out_last
);

    localparam int FB    = frame_beats(IMAGE_DIM, PIXELS_PER_BEAT);
    localparam int CNT_W = (FB > 1) ? $clog2(FB) : 1;

    logic [SSIM_LAT-1:0] vld_q, lst_q;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                accept, at_last;
    logic [2:0]          lane_en;

    // A beat moves only when in_valid & ~stall; while stalled upstream keeps
    // the beat on its inputs and every register here holds.
    assign accept     = in_valid & ~stall;
    assign at_last    = (beat_cnt_q == CNT_W'(FB - 1));
    assign beat_cnt_d = at_last ? '0 : beat_cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld_q      <= '0;
            lst_q      <= '0;
            beat_cnt_q <= '0;
        end else if (!stall) begin
            vld_q <= {vld_q[SSIM_LAT-2:0], in_valid};
            lst_q <= {lst_q[SSIM_LAT-2:0], in_valid & at_last};
            if (in_valid) begin
                beat_cnt_q <= beat_cnt_d;
            end
        end
    end

    assign lane_en   = {vld_q[1] & ~stall, vld_q[0] & ~stall, accept};
    assign out_valid = vld_q[SSIM_LAT-1];
    assign out_last  = lst_q[SSIM_LAT-1];

    for (genvar j = 0; j < PIXELS_PER_BEAT; j++) begin : g_lane
        ssim_lane #(
            .C1(C1),
            .C2(C2)
        ) u_lane (
            .clk       (clk),
            .aresetn   (aresetn),
            .en_i      (lane_en),
            .mu_x_i    (mu_x[j*MU_W +: MU_W]),
            .mu_y_i    (mu_y[j*MU_W +: MU_W]),
            .sigma_xy_i(sigma_xy[j*SIG_W +: SIG_W]),
            .sigma_x2_i(sigma_x2[j*SIG_W +: SIG_W]),
            .sigma_y2_i(sigma_y2[j*SIG_W +: SIG_W]),
            .num_o     (num[j*OUT_W +: OUT_W]),
            .den_o     (den[j*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_ssim_num_den.sv
// Directed bench for ssim_num_den with a 16x16 image and 16 lanes (one frame
// = 16 beats); single-beat arithmetic vectors plus stall, frame and reset streams.
module tb_ssim_num_den;

    localparam int PPB = 16;
    localparam int DIM = 16;
    localparam int FB  = 16;
    localparam int NW  = 36 * PPB;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic              stall = 1'b0;
    logic              in_valid = 1'b0;
    logic [8*PPB-1:0]  mu_x = '0, mu_y = '0;
    logic [16*PPB-1:0] sigma_xy = '0, sigma_x2 = '0, sigma_y2 = '0;
    logic [NW-1:0]     num, den;
    logic              out_valid, out_last;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: [31:12] emerge edge, [11] last flag, [10:0] beat index.
    logic [31:0] exp_q[$];
    int          ns_edge;
    int          frame_pos;
    int          last_seen;
    logic [35:0] held_num[PPB];
    logic [35:0] held_den[PPB];
    logic        held_valid, held_last;

    ssim_num_den #(
        .PIXELS_PER_BEAT(PPB),
        .IMAGE_DIM      (DIM),
        .C1             (7),
        .C2             (59)
    ) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .stall    (stall),
        .in_valid (in_valid),
        .mu_x     (mu_x),
        .mu_y     (mu_y),
        .sigma_xy (sigma_xy),
        .sigma_x2 (sigma_x2),
        .sigma_y2 (sigma_y2),
        .num      (num),
        .den      (den),
        .out_valid(out_valid),
        .out_last (out_last)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        ns_edge    = 0;
        frame_pos  = 0;
        last_seen  = 0;
        held_valid = 1'b0;
        held_last  = 1'b0;
        for (int j = 0; j < PPB; j++) begin
            held_num[j] = '0;
            held_den[j] = '0;
        end
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        clear_model();
    endtask

    // ---------------- drivers ----------------
    task automatic set_lane(input int j, input logic [7:0] mx, input logic [7:0] my,
                            input logic [15:0] sxy, input logic [15:0] sx2, input logic [15:0] sy2);
        mu_x[j*8 +: 8]       = mx;
        mu_y[j*8 +: 8]       = my;
        sigma_xy[j*16 +: 16] = sxy;
        sigma_x2[j*16 +: 16] = sx2;
        sigma_y2[j*16 +: 16] = sy2;
    endtask

    task automatic set_all(input logic [7:0] mx, input logic [7:0] my,
                           input logic [15:0] sxy, input logic [15:0] sx2, input logic [15:0] sy2);
        for (int j = 0; j < PPB; j++) set_lane(j, mx, my, sxy, sx2, sy2);
    endtask

    // One accepted beat followed by bubbles until it reaches the output.
    task automatic launch_single();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    // Stream beat b, lane j: mu_x=b+j, mu_y=2, sxy=b-8, sx2=10j, sy2=b.
    task automatic drive_stream_beat(input int b);
        for (int j = 0; j < PPB; j++)
            set_lane(j, 8'(b + j), 8'd2, 16'(b - 8), 16'(j * 10), 16'(b));
    endtask

    function automatic logic [35:0] exp_num(input int b, input int j);
        longint a, bb;
        a  = 4 * (b + j) + 7;
        bb = 2 * (b - 8) + 59;
        return 36'(a * bb);
    endfunction

    function automatic logic [35:0] exp_den(input int b, input int j);
        longint d1, d2;
        d1 = longint'((b + j) * (b + j)) + 11;
        d2 = longint'(j * 10 + b + 59);
        return 36'(d1 * d2);
    endfunction

    // Drives n stream beats (optional stall window), scoring every cycle
    // against the expected queue; drain=0 leaves in-flight beats in the pipe.
    task automatic run_stream(input string name, input int n, input int stall_at,
                              input int stall_len, input bit drain);
        int          sent  = 0;
        int          cyc   = 0;
        int          limit = n + stall_len + 20;
        int          b;
        bit          st;
        logic [31:0] item;
        logic [NW-1:0] en_bus, ed_bus;
        while ((sent < n || (drain && exp_q.size() > 0)) && cyc < limit) begin
            st       = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            stall    = st;
            in_valid = (sent < n);
            if (sent < n) drive_stream_beat(sent);
            if (in_valid && !st) begin
                item = {20'(ns_edge + 2), (frame_pos == FB - 1), 11'(sent)};
                exp_q.push_back(item);
                frame_pos = (frame_pos == FB - 1) ? 0 : frame_pos + 1;
                sent++;
            end
            tick();
            cyc++;
            if (!st) begin
                if (exp_q.size() > 0 && int'(exp_q[0][31:12]) == ns_edge) begin
                    item       = exp_q.pop_front();
                    b          = int'(item[10:0]);
                    held_valid = 1'b1;
                    held_last  = item[11];
                    for (int j = 0; j < PPB; j++) begin
                        held_num[j] = exp_num(b, j);
                        held_den[j] = exp_den(b, j);
                    end
                end else begin
                    held_valid = 1'b0;
                    held_last  = 1'b0;
                end
                ns_edge++;
                if (out_last) last_seen++;
            end
            for (int j = 0; j < PPB; j++) begin
                en_bus[j*36 +: 36] = held_num[j];
                ed_bus[j*36 +: 36] = held_den[j];
            end
            checks++;
            if (out_valid !== held_valid) begin
                errors++;
                $display("FAIL %s out_valid cyc=%0d got=%b exp=%b", name, cyc, out_valid, held_valid);
            end
            checks++;
            if (out_last !== held_last) begin
                errors++;
                $display("FAIL %s out_last cyc=%0d got=%b exp=%b", name, cyc, out_last, held_last);
            end
            checks++;
            if (num !== en_bus) begin
                errors++;
                $display("FAIL %s num cyc=%0d got=%h exp=%h", name, cyc, num, en_bus);
            end
            checks++;
            if (den !== ed_bus) begin
                errors++;
                $display("FAIL %s den cyc=%0d got=%h exp=%h", name, cyc, den, ed_bus);
            end
        end
        stall    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (cyc >= limit) begin
            errors++;
            $display("FAIL %s timeout sent=%0d pending=%0d exp_done=1", name, sent, exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        aresetn = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset out_last got=%b exp=0", out_last); end
        checks++;
        if (num !== '0) begin errors++; $display("FAIL reset num got=%h exp=0", num); end
        checks++;
        if (den !== '0) begin errors++; $display("FAIL reset den got=%h exp=0", den); end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        logic [NW-1:0] e;
        e = {PPB{36'd3181113}};
        set_all(8'd100, 8'd100, 16'd50, 16'd60, 16'd40);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL nominal early_valid got=%b exp=0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL nominal valid got=%b exp=1", out_valid); end
        checks++;
        if (num !== e) begin errors++; $display("FAIL nominal num got=%h exp=%h", num, e); end
        checks++;
        if (den !== e) begin errors++; $display("FAIL nominal den got=%h exp=%h", den, e); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL nominal valid_drop got=%b exp=0", out_valid); end
        checks++;
        if (num !== e) begin errors++; $display("FAIL nominal num_hold got=%h exp=%h", num, e); end
    endtask

    task automatic test_negative_cov();
        logic [35:0]   nv;
        logic [NW-1:0] en, ed;
        nv = -36'sd2820987;
        en = {PPB{nv}};
        ed = {PPB{36'd3181113}};
        set_all(8'd100, 8'd100, -16'sd100, 16'd60, 16'd40);
        launch_single();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL negcov valid got=%b exp=1", out_valid); end
        checks++;
        if (num !== en) begin errors++; $display("FAIL negcov num got=%h exp=%h", num, en); end
        checks++;
        if (den !== ed) begin errors++; $display("FAIL negcov den got=%h exp=%h", den, ed); end
    endtask

    task automatic test_extremes();
        logic [NW-1:0] en, ed;
        en = {PPB{36'd8530828801}};
        ed = {PPB{36'd17054244353}};
        set_all(8'd255, 8'd255, 16'd32767, 16'd65535, 16'd65535);
        launch_single();
        checks++;
        if (num !== en) begin errors++; $display("FAIL extremes num got=%h exp=%h", num, en); end
        checks++;
        if (den !== ed) begin errors++; $display("FAIL extremes den got=%h exp=%h", den, ed); end
    endtask

    // Lane 0 nominal, lane 1 negative covariance, lane 2 extremes, others zero (413).
    task automatic test_mixed_lanes();
        logic [NW-1:0] en, ed;
        logic [35:0]   nv;
        nv = -36'sd2820987;
        en = {PPB{36'd413}};
        ed = {PPB{36'd413}};
        en[0*36 +: 36] = 36'd3181113;
        ed[0*36 +: 36] = 36'd3181113;
        en[1*36 +: 36] = nv;
        ed[1*36 +: 36] = 36'd3181113;
        en[2*36 +: 36] = 36'd8530828801;
        ed[2*36 +: 36] = 36'd17054244353;
        set_all(8'd0, 8'd0, 16'd0, 16'd0, 16'd0);
        set_lane(0, 8'd100, 8'd100, 16'd50, 16'd60, 16'd40);
        set_lane(1, 8'd100, 8'd100, -16'sd100, 16'd60, 16'd40);
        set_lane(2, 8'd255, 8'd255, 16'd32767, 16'd65535, 16'd65535);
        launch_single();
        checks++;
        if (num !== en) begin errors++; $display("FAIL mixed num got=%h exp=%h", num, en); end
        checks++;
        if (den !== ed) begin errors++; $display("FAIL mixed den got=%h exp=%h", den, ed); end
    endtask

    task automatic test_stall();
        do_reset();
        run_stream("stall", 10, 4, 5, 1'b1);
    endtask

    task automatic test_frame();
        do_reset();
        run_stream("frame", 40, 1000, 0, 1'b1);
        checks++;
        if (last_seen !== 2) begin errors++; $display("FAIL frame last_count got=%0d exp=2", last_seen); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        run_stream("pre_reset", 7, 1000, 0, 1'b0);
        aresetn = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset valid got=%b exp=0", out_valid); end
        checks++;
        if (num !== '0) begin errors++; $display("FAIL midreset num got=%h exp=0", num); end
        tick();
        aresetn = 1'b1;
        clear_model();
        run_stream("post_reset", 16, 1000, 0, 1'b1);
        checks++;
        if (last_seen !== 1) begin errors++; $display("FAIL midreset last_count got=%0d exp=1", last_seen); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        clear_model();
        test_reset();
        test_nominal();
        test_negative_cov();
        test_extremes();
        test_mixed_lanes();
        test_stall();
        test_frame();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
